// File: rtl/shape_processor_ctrl_driver_if.sv
// CTRL SFR bus between the ctrl driver (master) and the shape processor (slave).
// read_data is valid in the same cycle that read is high.
interface shape_processor_ctrl_driver_if;
    logic        write;
    logic [31:0] write_data;
    logic        read;
    logic [31:0] read_data;

    modport master (output write, output write_data, output read, input read_data);
    modport slave  (input write, input write_data, input read, output read_data);
endinterface

// File: rtl/shape_processor_ctrl_driver.sv
// CTRL SFR driver: writes one (shape, operation) request, reads it back, and
// checks the read-back against a shadow of the SFR.
package shape_processor_modeling;
    typedef enum logic [2:0] {
        CIRCLE     = 3'd0,
        RECTANGLE  = 3'd1,
        TRIANGLE   = 3'd2,
        KEEP_SHAPE = 3'd7
    } shape_e;

    typedef enum logic [2:0] {
        AREA           = 3'd0,
        PERIMETER      = 3'd1,
        IS_SQUARE      = 3'd2,
        IS_EQUILATERAL = 3'd3,
        KEEP_OPERATION = 3'd7
    } operation_e;

    localparam int SHAPE_W   = $bits(shape_e);
    localparam int OP_W      = $bits(operation_e);
    localparam int SHAPE_LSB = 0;
    localparam int OP_LSB    = 4;

    typedef struct packed {
        logic [32-OP_W-1-SHAPE_W-1:0] rsvd_hi;
        logic [OP_W-1:0]              operation;
        logic                         rsvd_lo;
        logic [SHAPE_W-1:0]           shape;
    } ctrl_sfr_reg;

    function automatic logic is_reserved_shape(logic [SHAPE_W-1:0] s);
        case (s)
            CIRCLE, RECTANGLE, TRIANGLE, KEEP_SHAPE: return 1'b0;
            default:                                 return 1'b1;
        endcase
    endfunction

    function automatic logic is_reserved_operation(logic [OP_W-1:0] o);
        case (o)
            AREA, PERIMETER, IS_SQUARE, IS_EQUILATERAL, KEEP_OPERATION: return 1'b0;
            default:                                                   return 1'b1;
        endcase
    endfunction

    function automatic logic is_legal_combination(logic [SHAPE_W-1:0] s, logic [OP_W-1:0] o);
        case (o)
            AREA, PERIMETER: return (s == CIRCLE) || (s == RECTANGLE) || (s == TRIANGLE);
            IS_SQUARE:       return s == RECTANGLE;
            IS_EQUILATERAL:  return s == TRIANGLE;
            default:         return 1'b0;
        endcase
    endfunction
endpackage

module shape_processor_ctrl_driver
    import shape_processor_modeling::*;
#(
    parameter int READ_GAP     = 0,
    parameter bit SEND_ILLEGAL = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    shape_processor_ctrl_driver_if.master bus,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [SHAPE_W-1:0]            req_shape,
    input  logic [OP_W-1:0]               req_operation,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_accepted,
    output logic                          rsp_mismatch,
    output logic [SHAPE_W-1:0]            rsp_shape,
    output logic [OP_W-1:0]               rsp_operation
);
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITE, S_GAP, S_READ, S_RESP} state_e;

    localparam logic [3:0] GAP_LOAD = 4'((READ_GAP > 0) ? READ_GAP - 1 : 0);

    state_e             state_q;
    logic               write_q, read_q, req_ready_q, rsp_valid_q;
    logic               rsp_accepted_q, rsp_mismatch_q, legal_q;
    ctrl_sfr_reg        write_data_q;
    logic [3:0]         gap_cnt_q;
    logic [SHAPE_W-1:0] shadow_shape_q, exp_shape_q, rsp_shape_q;
    logic [OP_W-1:0]    shadow_op_q, exp_op_q, rsp_op_q;

    logic [SHAPE_W-1:0] eff_shape_d, rd_shape;
    logic [OP_W-1:0]    eff_op_d, rd_op;
    logic               legal_d;
    ctrl_sfr_reg        write_data_d;

    assign rd_shape = bus.read_data[SHAPE_LSB +: SHAPE_W];
    assign rd_op    = bus.read_data[OP_LSB +: OP_W];

    // KEEP_* codes resolve against the shadow, but the raw codes go on the bus.
    always_comb begin
        eff_shape_d = (req_shape == KEEP_SHAPE) ? shadow_shape_q : req_shape;
        eff_op_d    = (req_operation == KEEP_OPERATION) ? shadow_op_q : req_operation;
        legal_d     = !is_reserved_shape(req_shape) && !is_reserved_operation(req_operation)
                      && is_legal_combination(eff_shape_d, eff_op_d);
        write_data_d           = '0;
        write_data_d.shape     = req_shape;
        write_data_d.operation = req_operation;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_INIT;
            write_q        <= 1'b0;
            read_q         <= 1'b0;
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_accepted_q <= 1'b0;
            rsp_mismatch_q <= 1'b0;
            legal_q        <= 1'b0;
            write_data_q   <= '0;
            gap_cnt_q      <= '0;
            shadow_shape_q <= '0;
            shadow_op_q    <= '0;
            exp_shape_q    <= '0;
            exp_op_q       <= '0;
            rsp_shape_q    <= '0;
            rsp_op_q       <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (!read_q) begin
                        read_q <= 1'b1;
                    end else begin
                        read_q         <= 1'b0;
                        shadow_shape_q <= rd_shape;
                        shadow_op_q    <= rd_op;
                        req_ready_q    <= 1'b1;
                        state_q        <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        legal_q     <= legal_d;
                        exp_shape_q <= legal_d ? eff_shape_d : shadow_shape_q;
                        exp_op_q    <= legal_d ? eff_op_d : shadow_op_q;
                        if (legal_d || SEND_ILLEGAL) begin
                            write_q      <= 1'b1;
                            write_data_q <= write_data_d;
                            state_q      <= S_WRITE;
                        end else if (READ_GAP > 0) begin
                            gap_cnt_q <= GAP_LOAD;
                            state_q   <= S_GAP;
                        end else begin
                            read_q  <= 1'b1;
                            state_q <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    write_q <= 1'b0;
                    if (READ_GAP > 0) begin
                        gap_cnt_q <= GAP_LOAD;
                        state_q   <= S_GAP;
                    end else begin
                        read_q  <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == 4'd0) begin
                        read_q  <= 1'b1;
                        state_q <= S_READ;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                S_READ: begin
                    // Shadow follows the bus, not the expectation, so one bad read is not sticky.
                    read_q         <= 1'b0;
                    rsp_shape_q    <= rd_shape;
                    rsp_op_q       <= rd_op;
                    rsp_mismatch_q <= (rd_shape != exp_shape_q) || (rd_op != exp_op_q);
                    rsp_accepted_q <= legal_q;
                    shadow_shape_q <= rd_shape;
                    shadow_op_q    <= rd_op;
                    rsp_valid_q    <= 1'b1;
                    state_q        <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign bus.write      = write_q;
    assign bus.write_data = write_data_q;
    assign bus.read       = read_q;
    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_accepted   = rsp_accepted_q;
    assign rsp_mismatch   = rsp_mismatch_q;
    assign rsp_shape      = rsp_shape_q;
    assign rsp_operation  = rsp_op_q;
endmodule

// File: tb/tb_shape_processor_ctrl_driver.sv
// Bench for shape_processor_ctrl_driver: two instances (gap 0 / send illegal, gap 3 / skip illegal)
// against an SFR responder, with a request-level reference model predicting every response.
module tb_shape_processor_ctrl_driver;
    localparam logic [2:0] CIR = 3'd0, REC = 3'd1, TRI = 3'd2, KS = 3'd7;
    localparam logic [2:0] AREA = 3'd0, PER = 3'd1, SQ = 3'd2, EQ = 3'd3, KO = 3'd7;
    localparam int GAPS [2] = '{0, 3};
    localparam bit SENDI [2] = '{1'b1, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req_valid, rsp_ready;
    logic [2:0] req_shape, req_op;
    int         sel;
    logic       corrupt0, corrupt1;
    int         checks, failures;

    shape_processor_ctrl_driver_if bus0 ();
    shape_processor_ctrl_driver_if bus1 ();

    logic       rr [2], rv [2], ra [2], rm [2];
    logic [2:0] rs [2], ro [2];

    shape_processor_ctrl_driver #(.READ_GAP(0), .SEND_ILLEGAL(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .req_valid(req_valid && sel == 0), .req_ready(rr[0]),
        .req_shape(req_shape), .req_operation(req_op),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready && sel == 0),
        .rsp_accepted(ra[0]), .rsp_mismatch(rm[0]),
        .rsp_shape(rs[0]), .rsp_operation(ro[0]));

    shape_processor_ctrl_driver #(.READ_GAP(3), .SEND_ILLEGAL(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .req_valid(req_valid && sel == 1), .req_ready(rr[1]),
        .req_shape(req_shape), .req_operation(req_op),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready && sel == 1),
        .rsp_accepted(ra[1]), .rsp_mismatch(rm[1]),
        .rsp_shape(rs[1]), .rsp_operation(ro[1]));

    // Spec-level rules of the CTRL SFR.
    function automatic logic res_s(logic [2:0] s);
        return s >= 3'd3 && s <= 3'd6;
    endfunction
    function automatic logic res_o(logic [2:0] o);
        return o >= 3'd4 && o <= 3'd6;
    endfunction
    function automatic logic combo(logic [2:0] s, logic [2:0] o);
        return ((o == AREA || o == PER) && s <= TRI) || (o == SQ && s == REC) || (o == EQ && s == TRI);
    endfunction
    function automatic logic legal_of(logic [2:0] cs, logic [2:0] co, logic [2:0] qs, logic [2:0] qo);
        return !res_s(qs) && !res_o(qo) && combo(qs == KS ? cs : qs, qo == KO ? co : qo);
    endfunction
    function automatic logic [5:0] apply(logic [2:0] cs, logic [2:0] co, logic [2:0] qs, logic [2:0] qo);
        if (legal_of(cs, co, qs, qo)) return {(qs == KS ? cs : qs), (qo == KO ? co : qo)};
        return {cs, co};
    endfunction

    // SFR responders: update on write, corrupt OPERATION on read when asked.
    logic [2:0] sfr_s0, sfr_o0, sfr_s1, sfr_o1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sfr_s0 <= 3'd0; sfr_o0 <= 3'd0;
        end else if (bus0.write) begin
            {sfr_s0, sfr_o0} <= apply(sfr_s0, sfr_o0, bus0.write_data[2:0], bus0.write_data[6:4]);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sfr_s1 <= 3'd0; sfr_o1 <= 3'd0;
        end else if (bus1.write) begin
            {sfr_s1, sfr_o1} <= apply(sfr_s1, sfr_o1, bus1.write_data[2:0], bus1.write_data[6:4]);
        end
    end
    assign bus0.read_data = bus0.read ? {25'd0, sfr_o0 ^ {2'b00, corrupt0}, 1'b0, sfr_s0} : 32'hFFFF_FFFF;
    assign bus1.read_data = bus1.read ? {25'd0, sfr_o1 ^ {2'b00, corrupt1}, 1'b0, sfr_s1} : 32'hFFFF_FFFF;

    logic        wr_s, rd_s, rr_s, rv_s;
    logic [31:0] wd_s;
    logic [9:0]  rsp_s;
    assign wr_s  = (sel == 1) ? bus1.write : bus0.write;
    assign rd_s  = (sel == 1) ? bus1.read : bus0.read;
    assign wd_s  = (sel == 1) ? bus1.write_data : bus0.write_data;
    assign rr_s  = (sel == 1) ? rr[1] : rr[0];
    assign rv_s  = (sel == 1) ? rv[1] : rv[0];
    assign rsp_s = (sel == 1) ? {rv[1], rr[1], ra[1], rm[1], rs[1], ro[1]}
                              : {rv[0], rr[0], ra[0], rm[0], rs[0], ro[0]};

    // Reference model: driver shadow and SFR contents per instance.
    logic [2:0] m_sh_s [2], m_sh_o [2], m_sfr_s [2], m_sfr_o [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sh_s[i] = 3'd0; m_sh_o[i] = 3'd0; m_sfr_s[i] = 3'd0; m_sfr_o[i] = 3'd0;
        end
    endtask

    task automatic txn(input int i, input logic [2:0] s, input logic [2:0] o, input int hold);
        logic legal, sent, mism, crp;
        logic [2:0] exp_s, exp_o, rb_s, rb_o;
        logic [31:0] wd;
        int n, wcyc, rcyc, vcyc, wcnt, rcnt, both, rexp;
        legal = legal_of(m_sh_s[i], m_sh_o[i], s, o);
        exp_s = legal ? (s == KS ? m_sh_s[i] : s) : m_sh_s[i];
        exp_o = legal ? (o == KO ? m_sh_o[i] : o) : m_sh_o[i];
        sent  = legal || SENDI[i];
        if (sent) {m_sfr_s[i], m_sfr_o[i]} = apply(m_sfr_s[i], m_sfr_o[i], s, o);
        crp   = (i == 1) ? corrupt1 : corrupt0;
        rb_s  = m_sfr_s[i];
        rb_o  = m_sfr_o[i] ^ {2'b00, crp};
        mism  = (rb_s != exp_s) || (rb_o != exp_o);
        rexp  = (sent ? 2 : 1) + GAPS[i];

        n = 0;
        while (!rr_s && n < 50) begin @(negedge clk); n++; end
        chk("req_ready_before_accept", 32'(rr_s), 32'd1);
        req_valid = 1'b1; req_shape = s; req_op = o;
        @(posedge clk);
        wcyc = -1; rcyc = -1; vcyc = -1; wcnt = 0; rcnt = 0; both = 0; wd = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (wr_s) begin wcnt++; if (wcyc < 0) begin wcyc = k; wd = wd_s; end end
            if (rd_s) begin rcnt++; if (rcyc < 0) rcyc = k; end
            if (wr_s && rd_s) both++;
            if (rv_s) begin vcyc = k; break; end
        end
        chk("write_count", 32'(wcnt), sent ? 32'd1 : 32'd0);
        if (sent) begin
            chk("write_cycle", 32'(wcyc), 32'd1);
            chk("write_data", wd, {25'd0, o, 1'b0, s});
        end
        chk("read_count", 32'(rcnt), 32'd1);
        chk("read_cycle", 32'(rcyc), 32'(rexp));
        chk("rsp_valid_cycle", 32'(vcyc), 32'(rexp + 1));
        chk("write_read_overlap", 32'(both), 32'd0);
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            chk("rsp_fields", 32'(rsp_s), 32'({1'b1, 1'b0, legal, mism, rb_s, rb_o}));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("after_handshake_valid_ready", 32'({rv_s, rr_s}), 32'b01);
        m_sh_s[i] = rb_s;
        m_sh_o[i] = rb_o;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_shape = 3'd0; req_op = 3'd0; sel = 0;
        corrupt0 = 1'b0; corrupt1 = 1'b0;
        model_reset();

        @(negedge clk);
        chk("reset_outputs", {18'd0, rsp_s, 1'b0, wr_s, rd_s, rr_s}, 32'd0);
        chk("reset_write_data", wd_s, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_cycle1_rd_wr_rdy", 32'({rd_s, wr_s, rr_s}), 32'b100);
        @(negedge clk);
        chk("init_cycle2_rd_wr_rdy", 32'({rd_s, wr_s, rr_s}), 32'b001);

        // Instance 0: no gap, illegal requests still written.
        txn(0, CIR, AREA, 0);
        txn(0, REC, AREA, 2);
        txn(0, KS, SQ, 0);
        txn(0, CIR, AREA, 1);
        txn(0, 3'd5, AREA, 0);
        corrupt0 = 1'b1;
        txn(0, REC, AREA, 0);
        corrupt0 = 1'b0;
        txn(0, REC, AREA, 0);
        txn(0, KS, KO, 0);
        for (int t = 0; t < 20; t++)
            txn(0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

        // Instance 1: three gap cycles, illegal requests only read back.
        sel = 1;
        @(negedge clk);
        txn(1, CIR, AREA, 5);
        txn(1, 3'd4, AREA, 0);
        txn(1, TRI, EQ, 2);
        txn(1, REC, SQ, 0);
        for (int t = 0; t < 15; t++)
            txn(1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

        // Reset in the middle of the gap drops the request.
        req_valid = 1'b1; req_shape = REC; req_op = PER;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("midgap_write_pulse", 32'(wr_s), 32'd1);
        @(negedge clk);
        chk("midgap_idle_bus", 32'({wr_s, rd_s}), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midgap_reset_outputs", {18'd0, rsp_s, 1'b0, wr_s, rd_s, rr_s}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_init_read", 32'({rd_s, wr_s, rv_s}), 32'b100);
        @(negedge clk);
        chk("post_reset_ready", 32'({rd_s, rv_s, rr_s}), 32'b001);
        txn(1, TRI, EQ, 0);
        sel = 0;
        @(negedge clk);
        txn(0, REC, PER, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
